// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: opcode encodings, ALU operation codes and
// the sequencer state enum. The datapath decoder imports the same package.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEMWAIT,
        ST_HALTED
    } state_t;

    // ALU operation applied to the read data of a memory-read opcode.
    function automatic logic [1:0] alu_for_op(input logic [3:0] op);
        logic [1:0] res;
        res = ALU_PASS;
        case (op)
            OP_ADD:  res = ALU_ADD;
            OP_SUB:  res = ALU_SUB;
            default: res = ALU_PASS;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts data-memory wait cycles; expire fires in the wait cycle that would bring the
// count up to MEM_TOUT. MEM_TOUT of zero disables expiry entirely.
module mem_timeout_ctr #(
    parameter int MEM_TOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int CW = (MEM_TOUT > 0) ? $clog2(MEM_TOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((MEM_TOUT > 0) ? (MEM_TOUT - 1) : 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expire = (MEM_TOUT != 0) && inc && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && !expire) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 4-bit CPU. One instruction in flight; memory
// strobes and addresses are registered, single-cycle pulses are decoded from state.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW      = 4,
    parameter int ADW      = 4,
    parameter int MEM_TOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [OPW+ADW-1:0] instr,
    input  logic               instr_valid,
    input  logic               zero_flag,
    input  logic               mem_ack,
    output logic               ir_load_en,
    output logic               jump_en,
    output logic [ADW-1:0]     jump_addr,
    output logic               halt,
    output logic               acc_load_en,
    output logic [1:0]         alu_op,
    output logic               mem_rd_en,
    output logic               mem_wr_en,
    output logic [ADW-1:0]     mem_addr,
    output logic               illegal_op,
    output logic               bus_err
);

    state_t               state_q, state_d;
    logic [OPW+ADW-1:0]   ir_q, ir_d;
    logic [ADW-1:0]       jump_addr_q, jump_addr_d;
    logic [ADW-1:0]       mem_addr_q, mem_addr_d;
    logic [1:0]           alu_op_q, alu_op_d;
    logic                 mem_rd_q, mem_rd_d;
    logic                 mem_wr_q, mem_wr_d;
    logic                 halt_q, halt_d;
    logic                 illegal_q, illegal_d;
    logic                 bus_err_q, bus_err_d;

    logic [OPW-1:0]       opcode;
    logic                 tout_clear;
    logic                 tout_inc;
    logic                 tout_expire;

    assign opcode     = ir_q[OPW+ADW-1:ADW];
    assign tout_clear = (state_q != ST_MEMWAIT);
    assign tout_inc   = (state_q == ST_MEMWAIT) && !mem_ack;

    mem_timeout_ctr #(
        .MEM_TOUT (MEM_TOUT)
    ) u_tout (
        .clk    (clk),
        .reset  (reset),
        .clear  (tout_clear),
        .inc    (tout_inc),
        .expire (tout_expire)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        jump_addr_d = jump_addr_q;
        mem_addr_d  = mem_addr_q;
        alu_op_d    = alu_op_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        ir_load_en  = 1'b0;
        jump_en     = 1'b0;
        acc_load_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

            // Dropping run here abandons the fetch; once IR is loaded the instruction completes.
            ST_FETCH: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (instr_valid) begin
                    ir_load_en = 1'b1;
                    ir_d       = instr;
                    state_d    = ST_DECODE;
                end
            end

            ST_DECODE: begin
                mem_addr_d  = ir_q[ADW-1:0];
                jump_addr_d = ir_q[ADW-1:0];
                state_d     = ST_EXEC;
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                case (opcode)
                    OP_NOP: ;
                    OP_LDA, OP_ADD, OP_SUB: begin
                        mem_rd_d = 1'b1;
                        alu_op_d = alu_for_op(opcode);
                        state_d  = ST_MEMWAIT;
                    end
                    OP_STA: begin
                        mem_wr_d = 1'b1;
                        state_d  = ST_MEMWAIT;
                    end
                    OP_JMP:  jump_en = 1'b1;
                    OP_JZ:   jump_en = zero_flag;
                    OP_HLT:  state_d = ST_HALTED;
                    default: illegal_d = 1'b1;
                endcase
            end

            // Acknowledge wins over a timeout that would expire in the same cycle.
            ST_MEMWAIT: begin
                if (mem_ack) begin
                    acc_load_en = mem_rd_q;
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    state_d     = ST_FETCH;
                end else if (tout_expire) begin
                    bus_err_d = 1'b1;
                    mem_rd_d  = 1'b0;
                    mem_wr_d  = 1'b0;
                    state_d   = ST_HALTED;
                end
            end

            ST_HALTED: ;

            default: state_d = ST_IDLE;
        endcase

        halt_d = (state_d == ST_IDLE) || (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            jump_addr_q <= '0;
            mem_addr_q  <= '0;
            alu_op_q    <= ALU_PASS;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            halt_q      <= 1'b1;
            illegal_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            jump_addr_q <= jump_addr_d;
            mem_addr_q  <= mem_addr_d;
            alu_op_q    <= alu_op_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            halt_q      <= halt_d;
            illegal_q   <= illegal_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign jump_addr  = jump_addr_q;
    assign mem_addr   = mem_addr_q;
    assign alu_op     = alu_op_q;
    assign mem_rd_en  = mem_rd_q;
    assign mem_wr_en  = mem_wr_q;
    assign halt       = halt_q;
    assign illegal_op = illegal_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: inputs change on the falling edge, outputs are
// checked 1ns later, well away from the rising edge.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] instr;
    logic       instr_valid;
    logic       zero_flag;
    logic       mem_ack;
    logic       ir_load_en;
    logic       jump_en;
    logic [3:0] jump_addr;
    logic       halt;
    logic       acc_load_en;
    logic [1:0] alu_op;
    logic       mem_rd_en;
    logic       mem_wr_en;
    logic [3:0] mem_addr;
    logic       illegal_op;
    logic       bus_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .OPW      (4),
        .ADW      (4),
        .MEM_TOUT (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instr       (instr),
        .instr_valid (instr_valid),
        .zero_flag   (zero_flag),
        .mem_ack     (mem_ack),
        .ir_load_en  (ir_load_en),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .acc_load_en (acc_load_en),
        .alu_op      (alu_op),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .illegal_op  (illegal_op),
        .bus_err     (bus_err)
    );

    // From IDLE at a falling edge: raise run; returns at the falling edge of the FETCH cycle.
    task automatic start_run();
        run         = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
    endtask

    // From a FETCH falling edge: present one instruction; returns at the EXEC falling edge.
    task automatic issue(input logic [7:0] ins);
        instr       = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL reset_halt: got %b expected 1", halt); end
        checks++; if (ir_load_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_ir_load: got %b expected 0", ir_load_en); end
        checks++; if (jump_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_jump_en: got %b expected 0", jump_en); end
        checks++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin errors++; $display("[TB] FAIL reset_mem_en: got %b expected 00", {mem_rd_en, mem_wr_en}); end
        checks++; if (jump_addr !== 4'h0) begin errors++; $display("[TB] FAIL reset_jump_addr: got %h expected 0", jump_addr); end
        checks++; if (mem_addr !== 4'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (alu_op !== 2'b00) begin errors++; $display("[TB] FAIL reset_alu_op: got %b expected 00", alu_op); end
        checks++; if ({illegal_op, bus_err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_sticky: got %b expected 00", {illegal_op, bus_err}); end
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL idle_no_run_halt: got %b expected 1", halt); end
        @(negedge clk);
    endtask

    task automatic test_nop_stream();
        run         = 1'b1;
        instr       = 8'h00;
        instr_valid = 1'b1;
        #1;
        checks++; if (ir_load_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_ir_load: got %b expected 0", ir_load_en); end
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ir_load_en !== (k % 3 == 0)) begin
                errors++;
                $display("[TB] FAIL nop_ir_load[%0d]: got %b expected %b", k, ir_load_en, (k % 3 == 0));
            end
            checks++; if (jump_en !== 1'b0) begin errors++; $display("[TB] FAIL nop_jump_en[%0d]: got %b expected 0", k, jump_en); end
            checks++; if (halt !== 1'b0) begin errors++; $display("[TB] FAIL nop_halt[%0d]: got %b expected 0", k, halt); end
        end
        @(negedge clk);
        instr_valid = 1'b0;
        run         = 1'b0;
        #1;
        checks++; if (ir_load_en !== 1'b0) begin errors++; $display("[TB] FAIL runoff_ir_load: got %b expected 0", ir_load_en); end
        @(negedge clk);
        #1;
        checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL runoff_idle_halt: got %b expected 1", halt); end
        @(negedge clk);
    endtask

    task automatic test_jump();
        start_run();
        issue(8'h5A);
        #1;
        checks++; if (jump_en !== 1'b1) begin errors++; $display("[TB] FAIL jmp_jump_en: got %b expected 1", jump_en); end
        checks++; if (jump_addr !== 4'hA) begin errors++; $display("[TB] FAIL jmp_addr: got %h expected a", jump_addr); end
        checks++; if (ir_load_en !== 1'b0) begin errors++; $display("[TB] FAIL jmp_no_ir_load: got %b expected 0", ir_load_en); end
        @(negedge clk);
        #1;
        checks++; if (jump_en !== 1'b0) begin errors++; $display("[TB] FAIL jmp_pulse_width: got %b expected 0", jump_en); end
        zero_flag = 1'b0;
        issue(8'h6A);
        #1;
        checks++; if (jump_en !== 1'b0) begin errors++; $display("[TB] FAIL jz_not_taken: got %b expected 0", jump_en); end
        @(negedge clk);
        zero_flag = 1'b1;
        issue(8'h65);
        #1;
        checks++; if (jump_en !== 1'b1) begin errors++; $display("[TB] FAIL jz_taken: got %b expected 1", jump_en); end
        checks++; if (jump_addr !== 4'h5) begin errors++; $display("[TB] FAIL jz_addr: got %h expected 5", jump_addr); end
        @(negedge clk);
        zero_flag = 1'b0;
    endtask

    task automatic test_mem_read();
        int rd_cnt  = 0;
        int acc_cnt = 0;
        issue(8'h33);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            mem_ack = (i == 4);
            #1;
            if (mem_rd_en === 1'b1) begin
                rd_cnt++;
                checks++; if (alu_op !== 2'b01) begin errors++; $display("[TB] FAIL add_alu_op[%0d]: got %b expected 01", i, alu_op); end
                checks++; if (mem_addr !== 4'h3) begin errors++; $display("[TB] FAIL add_mem_addr[%0d]: got %h expected 3", i, mem_addr); end
            end
            if (acc_load_en === 1'b1) acc_cnt++;
            checks++;
            if (acc_load_en !== (i == 4)) begin
                errors++;
                $display("[TB] FAIL add_acc_load[%0d]: got %b expected %b", i, acc_load_en, (i == 4));
            end
            checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL add_no_wr[%0d]: got %b expected 0", i, mem_wr_en); end
        end
        checks++; if (rd_cnt != 5) begin errors++; $display("[TB] FAIL add_rd_cycles: got %0d expected 5", rd_cnt); end
        checks++; if (acc_cnt != 1) begin errors++; $display("[TB] FAIL add_acc_pulses: got %0d expected 1", acc_cnt); end
        @(negedge clk);
    endtask

    task automatic test_mem_write();
        int wr_cnt = 0;
        issue(8'h27);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ack = (i == 1);
            #1;
            if (mem_wr_en === 1'b1) begin
                wr_cnt++;
                checks++; if (mem_addr !== 4'h7) begin errors++; $display("[TB] FAIL sta_mem_addr[%0d]: got %h expected 7", i, mem_addr); end
            end
            checks++; if (acc_load_en !== 1'b0) begin errors++; $display("[TB] FAIL sta_no_acc[%0d]: got %b expected 0", i, acc_load_en); end
            checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL sta_no_rd[%0d]: got %b expected 0", i, mem_rd_en); end
        end
        mem_ack = 1'b0;
        checks++; if (wr_cnt != 2) begin errors++; $display("[TB] FAIL sta_wr_cycles: got %0d expected 2", wr_cnt); end
        @(negedge clk);
    endtask

    task automatic test_illegal_and_halt();
        issue(8'h9C);
        #1;
        checks++; if ({jump_en, illegal_op} !== 2'b00) begin errors++; $display("[TB] FAIL ill_exec: got %b expected 00", {jump_en, illegal_op}); end
        @(negedge clk);
        instr       = 8'h00;
        instr_valid = 1'b1;
        #1;
        checks++; if (illegal_op !== 1'b1) begin errors++; $display("[TB] FAIL ill_set: got %b expected 1", illegal_op); end
        checks++; if (ir_load_en !== 1'b1) begin errors++; $display("[TB] FAIL ill_next_fetch: got %b expected 1", ir_load_en); end
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        issue(8'hF0);
        #1;
        checks++; if (halt !== 1'b0) begin errors++; $display("[TB] FAIL hlt_exec_halt: got %b expected 0", halt); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            run         = i[0];
            instr_valid = 1'b1;
            #1;
            checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL hlt_halt[%0d]: got %b expected 1", i, halt); end
            checks++; if (ir_load_en !== 1'b0) begin errors++; $display("[TB] FAIL hlt_ir_load[%0d]: got %b expected 0", i, ir_load_en); end
            checks++; if (illegal_op !== 1'b1) begin errors++; $display("[TB] FAIL ill_sticky[%0d]: got %b expected 1", i, illegal_op); end
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int rd_cnt   = 0;
        int err_at   = -1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if ({illegal_op, halt} !== 2'b01) begin errors++; $display("[TB] FAIL tout_reset: got %b expected 01", {illegal_op, halt}); end
        @(negedge clk);
        reset = 1'b1;
        start_run();
        issue(8'h1B);
        mem_ack = 1'b0;
        for (int i = 0; i < 40 && err_at < 0; i++) begin
            @(negedge clk);
            #1;
            if (mem_rd_en === 1'b1) rd_cnt++;
            if (bus_err === 1'b1) err_at = i;
        end
        checks++; if (err_at != 15) begin errors++; $display("[TB] FAIL tout_bus_err_cycle: got %0d expected 15", err_at); end
        checks++; if (rd_cnt != 15) begin errors++; $display("[TB] FAIL tout_rd_cycles: got %0d expected 15", rd_cnt); end
        checks++; if ({mem_rd_en, acc_load_en} !== 2'b00) begin errors++; $display("[TB] FAIL tout_drop: got %b expected 00", {mem_rd_en, acc_load_en}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run         = ~run;
            instr_valid = 1'b1;
            #1;
            checks++; if ({halt, bus_err, ir_load_en} !== 3'b110) begin errors++; $display("[TB] FAIL tout_halted[%0d]: got %b expected 110", i, {halt, bus_err, ir_load_en}); end
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_reset_midwait();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start_run();
        issue(8'h4E);
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL midwait_rd: got %b expected 1", mem_rd_en); end
        checks++; if (alu_op !== 2'b10) begin errors++; $display("[TB] FAIL midwait_alu_op: got %b expected 10", alu_op); end
        checks++; if (mem_addr !== 4'hE) begin errors++; $display("[TB] FAIL midwait_addr: got %h expected e", mem_addr); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL async_rd_drop: got %b expected 0", mem_rd_en); end
        checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL async_halt: got %b expected 1", halt); end
        checks++; if ({alu_op, mem_addr} !== 6'h00) begin errors++; $display("[TB] FAIL async_regs: got %h expected 00", {alu_op, mem_addr}); end
        run = 1'b0;
        @(negedge clk);
        reset       = 1'b1;
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++; if ({halt, ir_load_en} !== 2'b10) begin errors++; $display("[TB] FAIL post_reset_idle[%0d]: got %b expected 10", i, {halt, ir_load_en}); end
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        run         = 1'b0;
        instr       = 8'h00;
        instr_valid = 1'b0;
        zero_flag   = 1'b0;
        mem_ack     = 1'b0;
        @(negedge clk);
        test_reset();
        test_nop_stream();
        test_jump();
        test_mem_read();
        test_mem_write();
        test_illegal_and_halt();
        test_timeout();
        test_reset_midwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
